// File: rtl/apb_fir_requester.sv
// APB initiator for the FIR accelerator slave port: turns valid/ready commands into
// single APB transfers or repeated status-poll reads, with a wait-state timeout.
module apb_fir_requester #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int POLL_LIMIT     = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic                  cmd_poll_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    input  logic [DATA_WIDTH-1:0] cmd_mask_i,
    input  logic [DATA_WIDTH-1:0] cmd_match_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pready_i,
    input  logic                  pslverr_i
);

    localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PCW = $clog2(POLL_LIMIT + 1);
    localparam logic [WCW-1:0] WAIT_ONE   = WCW'(1);
    localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(TIMEOUT_CYCLES);
    localparam logic [PCW-1:0] POLL_ONE   = PCW'(1);
    localparam logic [PCW-1:0] POLL_MAX   = PCW'(POLL_LIMIT);
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                state_q;
    logic [WCW-1:0]        wait_cnt_q;
    logic [WCW-1:0]        wait_cnt_d;
    logic [PCW-1:0]        poll_cnt_q;
    logic [PCW-1:0]        poll_cnt_d;
    logic                  poll_q;
    logic [DATA_WIDTH-1:0] mask_q;
    logic [DATA_WIDTH-1:0] match_q;
    logic                  wait_expired_d;
    logic                  poll_exhausted_d;
    logic                  poll_hit_d;
    logic [DATA_WIDTH-1:0] rd_capture_d;

    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;
    logic                  rsp_timeout_q;

    assign cmd_ready_o   = (state_q == ST_IDLE);
    assign psel_o        = psel_q;
    assign penable_o     = penable_q;
    assign pwrite_o      = pwrite_q;
    assign paddr_o       = paddr_q;
    assign pwdata_o      = pwdata_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_timeout_q;

    // Counter increments and completion decisions for the current ACCESS cycle.
    always_comb begin
        wait_cnt_d       = wait_cnt_q + WAIT_ONE;
        poll_cnt_d       = poll_cnt_q + POLL_ONE;
        wait_expired_d   = (wait_cnt_d == WAIT_LIMIT);
        // poll_cnt_q counts reads already completed, so this read is number poll_cnt_d.
        poll_exhausted_d = (poll_cnt_d == POLL_MAX);
        poll_hit_d       = ((prdata_i & mask_q) == match_q);
        rd_capture_d     = pwrite_q ? DATA_ZERO : prdata_i;
    end

    // Transfer sequencer with registered APB and response outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            wait_cnt_q    <= {WCW{1'b0}};
            poll_cnt_q    <= {PCW{1'b0}};
            poll_q        <= 1'b0;
            mask_q        <= DATA_ZERO;
            match_q       <= DATA_ZERO;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= ADDR_ZERO;
            pwdata_q      <= DATA_ZERO;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= DATA_ZERO;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rsp_valid_q <= 1'b0;
                    if (cmd_valid_i) begin
                        paddr_q    <= cmd_addr_i;
                        pwrite_q   <= cmd_write_i;
                        pwdata_q   <= cmd_write_i ? cmd_wdata_i : DATA_ZERO;
                        poll_q     <= cmd_poll_i & ~cmd_write_i;
                        mask_q     <= cmd_mask_i;
                        match_q    <= cmd_match_i & cmd_mask_i;
                        poll_cnt_q <= {PCW{1'b0}};
                        psel_q     <= 1'b1;
                        penable_q  <= 1'b0;
                        state_q    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_q  <= 1'b1;
                    wait_cnt_q <= {WCW{1'b0}};
                    state_q    <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (!pready_i) begin
                        wait_cnt_q <= wait_cnt_d;
                        if (wait_expired_d) begin
                            psel_q        <= 1'b0;
                            penable_q     <= 1'b0;
                            rsp_valid_q   <= 1'b1;
                            rsp_rdata_q   <= DATA_ZERO;
                            rsp_err_q     <= 1'b1;
                            rsp_timeout_q <= 1'b1;
                            state_q       <= ST_RESP;
                        end
                    end else begin
                        penable_q <= 1'b0;
                        if (pslverr_i || !poll_q || poll_hit_d || poll_exhausted_d) begin
                            psel_q        <= 1'b0;
                            rsp_valid_q   <= 1'b1;
                            rsp_rdata_q   <= rd_capture_d;
                            // A slave error wins over the poll outcome.
                            rsp_err_q     <= pslverr_i | (poll_q & ~poll_hit_d);
                            rsp_timeout_q <= ~pslverr_i & poll_q & ~poll_hit_d;
                            state_q       <= ST_RESP;
                        end else begin
                            poll_cnt_q <= poll_cnt_d;
                            state_q    <= ST_SETUP;
                        end
                    end
                end
                ST_RESP: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    psel_q      <= 1'b0;
                    penable_q   <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_fir_requester.sv
// Self-checking bench for apb_fir_requester: scripted APB slave plus a response
// scoreboard filled when commands are issued and drained on rsp_valid_o.
module tb_apb_fir_requester;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_write_i;
    logic        cmd_poll_i;
    logic [31:0] cmd_addr_i;
    logic [31:0] cmd_wdata_i;
    logic [31:0] cmd_mask_i;
    logic [31:0] cmd_match_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;
    logic [31:0] paddr_o;
    logic        psel_o;
    logic        penable_o;
    logic        pwrite_o;
    logic [31:0] pwdata_o;
    logic [31:0] prdata_i;
    logic        pready_i;
    logic        pslverr_i;

    always #5 clk = ~clk;

    apb_fir_requester dut (
        .clk_i(clk), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_write_i(cmd_write_i), .cmd_poll_i(cmd_poll_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
        .cmd_mask_i(cmd_mask_i), .cmd_match_i(cmd_match_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
        .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o),
        .pwrite_o(pwrite_o), .pwdata_o(pwdata_o),
        .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] slv_data_q[$];
    logic [31:0] slv_default;
    logic        slv_err;
    int          slv_waits;
    int          wait_left;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          accept_cyc, rsp_cyc, psel_cycles, penable_cycles, rd_count;
    bit          got_rsp;

    // One clock: sample outputs, drain scoreboard, then drive the slave for the new cycle.
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (psel_o) psel_cycles++;
        if (penable_o) penable_cycles++;
        if (rsp_valid_o) begin
            if (!got_rsp) rsp_cyc = cyc;
            got_rsp = 1'b1;
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_rsp got rdata=%h err=%b tmo=%b at cycle %0d",
                         rsp_rdata_o, rsp_err_o, rsp_timeout_o, cyc);
            end else begin
                e = sb_q.pop_front();
                if ({rsp_rdata_o, rsp_err_o, rsp_timeout_o} !== e) begin
                    bad++;
                    $display("FAIL rsp_fields got rdata=%h err=%b tmo=%b exp rdata=%h err=%b tmo=%b",
                             rsp_rdata_o, rsp_err_o, rsp_timeout_o, e.rdata, e.err, e.tmo);
                end
            end
        end
        pready_i  = 1'b0;
        pslverr_i = 1'b0;
        prdata_i  = 32'hDEAD_BEEF;
        if (psel_o && !penable_o) begin
            wait_left = slv_waits;
        end else if (psel_o && penable_o) begin
            if (wait_left > 0) begin
                wait_left--;
            end else begin
                pready_i  = 1'b1;
                pslverr_i = slv_err;
                if (slv_data_q.size() > 0) prdata_i = slv_data_q.pop_front();
                else prdata_i = slv_default;
                if (!pwrite_o) rd_count++;
            end
        end
    endtask

    task automatic issue(input logic wr, input logic poll, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] mask,
                         input logic [31:0] match, input bit expect_rsp, input exp_t e);
        int n = 0;
        while (!cmd_ready_o && n < 50) begin
            cycle();
            n++;
        end
        total++;
        if (!cmd_ready_o) begin
            bad++;
            $display("FAIL cmd_ready_wait got=%b exp=1", cmd_ready_o);
        end
        cmd_valid_i = 1'b1;
        cmd_write_i = wr;
        cmd_poll_i  = poll;
        cmd_addr_i  = addr;
        cmd_wdata_i = wdata;
        cmd_mask_i  = mask;
        cmd_match_i = match;
        if (expect_rsp) sb_q.push_back(e);
        psel_cycles    = 0;
        penable_cycles = 0;
        rd_count       = 0;
        got_rsp        = 1'b0;
        rsp_cyc        = -1;
        cycle();
        accept_cyc  = cyc;
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, input string name);
        int n = 0;
        while (!got_rsp && n < budget) begin
            cycle();
            n++;
        end
        total++;
        if (!got_rsp) begin
            bad++;
            $display("FAIL %s_no_rsp got none within %0d cycles exp one", name, budget);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        cycle();
        cycle();
        total++;
        if ({psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_err_o, rsp_timeout_o} !== 6'b0 ||
            paddr_o !== 32'h0 || pwdata_o !== 32'h0 || rsp_rdata_o !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs got psel=%b pen=%b pwr=%b rv=%b paddr=%h pwdata=%h rdata=%h exp all 0",
                     psel_o, penable_o, pwrite_o, rsp_valid_o, paddr_o, pwdata_o, rsp_rdata_o);
        end
        total++;
        if (cmd_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b exp=1", cmd_ready_o);
        end
        rst_i = 1'b0;
        cycle();
    endtask

    task automatic test_write();
        exp_t e;
        e = {32'h0, 1'b0, 1'b0};
        issue(1'b1, 1'b0, 32'h0C, 32'h5, 32'h0, 32'h0, 1'b1, e);
        total++;
        if (paddr_o !== 32'h0C || pwrite_o !== 1'b1 || pwdata_o !== 32'h5) begin
            bad++;
            $display("FAIL write_setup got paddr=%h pwrite=%b pwdata=%h exp 0c 1 5", paddr_o, pwrite_o, pwdata_o);
        end
        wait_rsp(10, "write");
        total++;
        if (rsp_cyc - accept_cyc !== 2 || psel_cycles !== 2 || penable_cycles !== 1) begin
            bad++;
            $display("FAIL write_timing got lat=%0d psel=%0d pen=%0d exp 2 2 1",
                     rsp_cyc - accept_cyc, psel_cycles, penable_cycles);
        end
        cycle();
        total++;
        if (rsp_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL write_pulse got rsp_valid=%b exp=0", rsp_valid_o);
        end
    endtask

    task automatic test_read_wait();
        exp_t e;
        slv_waits = 2;
        slv_data_q.push_back(32'h0000_1234);
        e = {32'h0000_1234, 1'b0, 1'b0};
        issue(1'b0, 1'b0, 32'h10, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1, e);
        total++;
        if (paddr_o !== 32'h10 || pwrite_o !== 1'b0 || pwdata_o !== 32'h0) begin
            bad++;
            $display("FAIL read_setup got paddr=%h pwrite=%b pwdata=%h exp 10 0 0", paddr_o, pwrite_o, pwdata_o);
        end
        wait_rsp(20, "read");
        total++;
        if (rsp_cyc - accept_cyc !== 4 || penable_cycles !== 3) begin
            bad++;
            $display("FAIL read_timing got lat=%0d pen=%0d exp 4 3", rsp_cyc - accept_cyc, penable_cycles);
        end
        cycle();
        cycle();
        total++;
        if (rsp_rdata_o !== 32'h0000_1234 || rsp_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL read_hold got rdata=%h rv=%b exp 00001234 0", rsp_rdata_o, rsp_valid_o);
        end
        slv_waits = 0;
    endtask

    task automatic test_poll_match();
        exp_t e;
        slv_data_q.push_back(32'h0);
        slv_data_q.push_back(32'h0);
        slv_data_q.push_back(32'h1);
        e = {32'h1, 1'b0, 1'b0};
        issue(1'b0, 1'b1, 32'h04, 32'h0, 32'h1, 32'h1, 1'b1, e);
        wait_rsp(40, "poll");
        total++;
        if (rd_count !== 3 || psel_cycles !== 6 || rsp_cyc - accept_cyc !== 6) begin
            bad++;
            $display("FAIL poll_reads got reads=%0d psel=%0d lat=%0d exp 3 6 6",
                     rd_count, psel_cycles, rsp_cyc - accept_cyc);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        slv_waits = 1000;
        e = {32'h0, 1'b1, 1'b1};
        issue(1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0, 1'b1, e);
        wait_rsp(40, "timeout");
        total++;
        if (penable_cycles !== 16 || psel_cycles !== 17 || rsp_cyc - accept_cyc !== 17) begin
            bad++;
            $display("FAIL timeout_len got pen=%0d psel=%0d lat=%0d exp 16 17 17",
                     penable_cycles, psel_cycles, rsp_cyc - accept_cyc);
        end
        slv_waits = 0;
    endtask

    task automatic test_slverr();
        exp_t e;
        slv_err = 1'b1;
        e = {32'h0, 1'b1, 1'b0};
        issue(1'b1, 1'b0, 32'h14, 32'hA5, 32'h0, 32'h0, 1'b1, e);
        wait_rsp(10, "slverr");
        slv_err = 1'b0;
    endtask

    task automatic test_poll_limit();
        exp_t e;
        slv_default = 32'h0;
        e = {32'h0, 1'b1, 1'b1};
        issue(1'b0, 1'b1, 32'h04, 32'h0, 32'h1, 32'h1, 1'b1, e);
        wait_rsp(300, "poll_limit");
        total++;
        if (rd_count !== 64 || rsp_cyc - accept_cyc !== 128) begin
            bad++;
            $display("FAIL poll_limit_reads got reads=%0d lat=%0d exp 64 128", rd_count, rsp_cyc - accept_cyc);
        end
    endtask

    task automatic test_write_poll();
        exp_t e;
        slv_default = 32'h0;
        e = {32'h0, 1'b0, 1'b0};
        issue(1'b1, 1'b1, 32'h00, 32'h3, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, e);
        wait_rsp(20, "write_poll");
        total++;
        if (psel_cycles !== 2 || rsp_cyc - accept_cyc !== 2 || rd_count !== 0) begin
            bad++;
            $display("FAIL write_poll_plain got psel=%0d lat=%0d reads=%0d exp 2 2 0",
                     psel_cycles, rsp_cyc - accept_cyc, rd_count);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        slv_data_q.push_back(32'h0000_0011);
        slv_data_q.push_back(32'h0000_0022);
        e = {32'h0000_0011, 1'b0, 1'b0};
        issue(1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0, 1'b1, e);
        wait_rsp(10, "b2b_first");
        e = {32'h0000_0022, 1'b0, 1'b0};
        issue(1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0, 1'b1, e);
        wait_rsp(10, "b2b_second");
    endtask

    task automatic test_reset_mid();
        exp_t e;
        slv_waits = 1000;
        e = {32'h0, 1'b0, 1'b0};
        issue(1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0, 1'b0, e);
        cycle();
        total++;
        if (penable_o !== 1'b1) begin
            bad++;
            $display("FAIL mid_access got penable=%b exp=1", penable_o);
        end
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        total++;
        if (psel_o !== 1'b0 || penable_o !== 1'b0 || rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset got psel=%b pen=%b rv=%b ready=%b exp 0 0 0 1",
                     psel_o, penable_o, rsp_valid_o, cmd_ready_o);
        end
        for (int i = 0; i < 5; i++) cycle();
        total++;
        if (got_rsp !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_rsp got response=%b exp=0", got_rsp);
        end
        slv_waits = 0;
    endtask

    initial begin
        rst_i       = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_write_i = 1'b0;
        cmd_poll_i  = 1'b0;
        cmd_addr_i  = 32'h0;
        cmd_wdata_i = 32'h0;
        cmd_mask_i  = 32'h0;
        cmd_match_i = 32'h0;
        prdata_i    = 32'h0;
        pready_i    = 1'b0;
        pslverr_i   = 1'b0;
        slv_default = 32'h0;
        slv_err     = 1'b0;
        slv_waits   = 0;
        wait_left   = 0;
        got_rsp     = 1'b0;
        test_reset();
        test_write();
        test_read_wait();
        test_poll_match();
        test_timeout();
        test_slverr();
        test_poll_limit();
        test_write_poll();
        test_back_to_back();
        test_reset_mid();
        total++;
        if (sb_q.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_drain got pending=%0d exp=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
